imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 192 +++++++++++++++++++
 tb/tb_imem_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a program image, one byte per valid/ready transfer,
// into the processor instruction memory. The processor is held with its PC
// at 0 until the whole image has been written.
//
// Byte stream: count word N (high byte, low byte), then N data words, each
// sent high byte first.
//
// Build option IMEM_LOADER_CHKSUM_EN: one trailing checksum word is expected
// after the data words. It must equal the 16-bit wrap-around sum of all the
// data words, otherwise the load ends in ERROR.
//
// Handshake: a byte moves when byte_valid and byte_ready are both 1 at a
// rising clk edge. byte_ready depends only on the state and on rst, never on
// byte_valid. byte_valid low simply stalls the loader, for any number of cycles.
module imem_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_LOAD_CNT  = 3'd0;
  localparam logic [2:0] S_LOAD_WORD = 3'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
  localparam logic [2:0] S_CHK       = 3'd2;
`endif
  localparam logic [2:0] S_DONE      = 3'd3;
  localparam logic [2:0] S_ERROR     = 3'd4;

  // Largest program that fits the 9-bit instruction address space.
  localparam logic [15:0] MAX_WORDS  = 16'd512;

  logic [2:0]  state_q, state_d;
  logic        phase_q, phase_d;     // 0: next byte is a high byte
  logic [7:0]  hi_q, hi_d;           // high byte of the word being assembled
  logic [9:0]  cnt_q, cnt_d;         // N, limited to 1..512 once loading
  logic [9:0]  idx_q, idx_d;         // index of the next data word
  logic        wr_en_q, wr_en_d;
  logic [8:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [15:0] sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] word;

  // A byte is taken in every state except the two terminal ones. Holding
  // ready low during rst keeps stray bytes from being taken while in reset.
  always_comb begin
    byte_ready = 1'b0;
    if (!rst) begin
      byte_ready = (state_q == S_LOAD_CNT) || (state_q == S_LOAD_WORD)
`ifdef IMEM_LOADER_CHKSUM_EN
                   || (state_q == S_CHK)
`endif
                   ;
    end
  end

  assign accept   = byte_valid & byte_ready;
  assign word     = {hi_q, byte_data};
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = ~done_q;

  // Next-state logic. Each word completes on its low byte. The write strobe
  // is registered, so it is high only in the cycle after that low byte.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    sum_d     = sum_q;
    if (state_q == S_LOAD_CNT) begin
      sum_d = 16'd0;
    end
`endif

    if (accept) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = byte_data;
      end else begin
        case (state_q)
          S_LOAD_CNT: begin
            if (word == 16'd0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
`endif
            end else if (word > MAX_WORDS) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end else begin
              state_d = S_LOAD_WORD;
              cnt_d   = word[9:0];
              idx_d   = 10'd0;
            end
          end
          S_LOAD_WORD: begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q[8:0];
            wr_data_d = word;
            idx_d     = idx_q + 10'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_d     = sum_q + word;
`endif
            if (idx_q == cnt_q - 10'd1) begin
`ifdef IMEM_LOADER_CHKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
`endif
            end
          end
`ifdef IMEM_LOADER_CHKSUM_EN
          S_CHK: begin
            if (word == sum_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end
          end
`endif
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  // State registers with synchronous reset. A partial word is dropped on
  // reset. Memory that has already been written is left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD_CNT;
      phase_q   <= 1'b0;
      hi_q      <= 8'd0;
      cnt_q     <= 10'd0;
      idx_q     <= 10'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 9'd0;
      wr_data_q <= 16'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q     <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Byte streams are built as queues. A word-level
// reference model turns each stream into the expected memory writes and the
// expected final done/err values. A negedge monitor pops and compares every
// write the loader makes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [24:0] exp_q[$];      // {addr[8:0], data[15:0]}
  logic [7:0]  stim_q[$];
  logic        exp_done;
  logic        exp_err;
  logic        last_done_exp; // done rises together with the final write

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference model: works on whole words, not on loader state.
  task automatic model_stream();
    logic [15:0] words[$];
    logic [15:0] n;
    logic [15:0] sum;
    int          nwords;
    exp_done      = 1'b0;
    exp_err       = 1'b0;
    last_done_exp = 1'b0;
    sum           = 16'd0;
    nwords        = stim_q.size() / 2;
    for (int i = 0; i < nwords; i++) words.push_back({stim_q[2*i], stim_q[2*i+1]});
    if (nwords >= 1) begin
      n = words[0];
      if (n > 16'd512) begin
        exp_err = 1'b1;
      end else begin
        for (int i = 0; i < int'(n) && i + 1 < nwords; i++) begin
          exp_q.push_back({9'(i), words[i+1]});
          sum = sum + words[i+1];
        end
`ifdef IMEM_LOADER_CHKSUM_EN
        if (nwords >= int'(n) + 2) begin
          if (words[int'(n) + 1] == sum) exp_done = 1'b1;
          else                            exp_err  = 1'b1;
        end
`else
        if (nwords >= int'(n) + 1) begin
          exp_done      = 1'b1;
          last_done_exp = (n != 16'd0);
        end
`endif
      end
    end
  endtask

  // Builds a load of n random words. Under the checksum build it appends the
  // checksum word, corrupted when bad_chk is set. It then adds a few trailing
  // bytes that must be ignored.
  task automatic build_load(input int n, input bit bad_chk, input int extra);
    logic [15:0] w;
    logic [15:0] s;
    s = 16'd0;
    w = 16'(n);
    stim_q.push_back(w[15:8]);
    stim_q.push_back(w[7:0]);
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      s = s + w;
      stim_q.push_back(w[15:8]);
      stim_q.push_back(w[7:0]);
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    if (bad_chk) s = s ^ 16'(1 << $urandom_range(0, 15));
    stim_q.push_back(s[15:8]);
    stim_q.push_back(s[7:0]);
`else
    if (bad_chk) s = ~s;
`endif
    for (int i = 0; i < extra; i++) stim_q.push_back(8'($urandom));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_byte_ready", byte_ready, 0);
    check("rst_wr_en",      wr_en, 0);
    check("rst_wr_addr",    wr_addr, 0);
    check("rst_wr_data",    wr_data, 0);
    check("rst_done",       done, 0);
    check("rst_err",        err, 0);
    check("rst_cpu_hold",   cpu_hold, 1);
    rst = 1'b0;
    #1;
    check("post_rst_byte_ready", byte_ready, 1);
  endtask

  // gap_mode 0: back-to-back bytes, 1: one idle cycle between bytes,
  // 2: random 0..3 idle cycles. byte_data carries junk while byte_valid is low.
  task automatic drive_stream(input int gap_mode);
    int gap;
    foreach (stim_q[i]) begin
      byte_valid = 1'b1;
      byte_data  = stim_q[i];
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
        byte_data = 8'($urandom);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d writes missing, expected 0 missing", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_case(input string name, input int gap_mode);
    model_stream();
    drive_stream(gap_mode);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check({name, "_done"},       done, exp_done);
    check({name, "_err"},        err, exp_err);
    check({name, "_cpu_hold"},   cpu_hold, !exp_done);
    check({name, "_byte_ready"}, byte_ready, !(exp_done || exp_err));
    stim_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [24:0] e;
    logic        d_exp;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        d_exp = (exp_q.size() == 0) && last_done_exp;
        check("wr_addr", wr_addr, e[24:16]);
        check("wr_data", wr_data, e[15:0]);
        check("done_at_write", done, d_exp);
        check("hold_at_write", cpu_hold, !d_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] s;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    last_done_exp = 1'b0;

    // Basic two-word load.
    do_reset();
    stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef IMEM_LOADER_CHKSUM_EN
    s = 16'h1234 + 16'hABCD;
    stim_q.push_back(s[15:8]);
    stim_q.push_back(s[7:0]);
`endif
    run_case("two_word", 0);

`ifdef IMEM_LOADER_CHKSUM_EN
    // Same load, checksum off by one.
    do_reset();
    stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    s = 16'h1234 + 16'hABCD + 16'd1;
    stim_q.push_back(s[15:8]);
    stim_q.push_back(s[7:0]);
    run_case("bad_chk", 0);
`endif

    // Count 513: error, no writes, later bytes ignored.
    do_reset();
    stim_q = '{8'h02, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run_case("count_513", 0);

    // Three-word load, gapless and then with alternating valid.
    do_reset();
    build_load(3, 1'b0, 0);
    run_case("three_gapless", 0);
    do_reset();
    build_load(3, 1'b0, 0);
    run_case("three_toggled", 1);

    // Reset after the high byte of word 1, then a clean restart.
    do_reset();
    stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    model_stream();
    drive_stream(0);
    drain();
    stim_q.delete();
    do_reset();
    build_load(2, 1'b0, 0);
    run_case("restart", 0);

    // Empty program, with trailing bytes that must be ignored.
    do_reset();
    stim_q = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHKSUM_EN
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h00);
`endif
    stim_q.push_back(8'h55);
    stim_q.push_back(8'h66);
    run_case("empty", 0);

    // Largest legal program: addresses 0..511.
    do_reset();
    build_load(512, 1'b0, 2);
    run_case("full_512", 0);

    // Random loads with random gaps and trailing junk.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      build_load($urandom_range(1, 24), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      run_case("random_load", 2);
    end

    // Random oversize counts.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      s = 16'($urandom_range(513, 65535));
      stim_q.push_back(s[15:8]);
      stim_q.push_back(s[7:0]);
      stim_q.push_back(8'($urandom));
      stim_q.push_back(8'($urandom));
      run_case("random_oversize", 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
